row_select_sequencer: RTL and testbench
=======================================

# row_select_sequencer

Parametrised, clocked row-select controller for the memory array. It accepts one row access per handshake, decodes the address to a one-hot word-line select, and sequences it through a precharge phase, an active phase and a completion pulse. A clear mode sweeps every row in turn. It sits between the access controller and the array's word-line drivers, and is the successor to the fixed 3-to-8 combinational decoder.

## Interface
Parameters:
- ADDR_W, default 3: row address width.
- ROWS, default 8: number of physical rows. Legal range is 2 ≤ ROWS ≤ 2**ADDR_W; an elaboration-time assertion enforces it.
- PRECHARGE_CYC, default 1: number of precharge cycles per row, ≥1.
- ACTIVE_CYC, default 2: number of cycles the word line is held, ≥1.

Ports:
- i_clk, in, 1: the single clock; all logic is on the rising edge.
- i_rst_n, in, 1: asynchronous, active-low reset.
- i_valid, in, 1: access request.
- o_ready, out, 1: block can accept a request.
- i_k_address, in, ADDR_W: row address, sampled on handshake.
- i_clear, in, 1: start a sweep of all rows, sampled on handshake.
- o_select, out, ROWS: one-hot word-line select; all zero when no row is active.
- o_precharge, out, 1: bit-line precharge enable.
- o_busy, out, 1: an access or sweep is in progress.
- o_done, out, 1: one-cycle completion pulse.
- o_err, out, 1: out-of-range address flag, valid only together with o_done.

## Operation
- **Handshake:** a request is accepted on a rising edge where (i_valid | i_clear) & o_ready. o_ready is 1 only in IDLE. All inputs are ignored when not accepted.
- **States:** IDLE, PRE, ACT, DONE.
  - IDLE → PRE on accept.
  - PRE → ACT after PRECHARGE_CYC cycles.
  - ACT → DONE after ACTIVE_CYC cycles, or ACT → PRE with row+1 when in sweep and the row is not the last.
  - DONE → IDLE after 1 cycle.
- **Outputs per state:**
  - PRE: o_precharge=1, o_select=0.
  - ACT: o_select has one-hot bit [row] set, o_precharge=0.
  - DONE: o_done=1, o_select=0.
  - o_busy=1 in PRE, ACT and DONE.
- **Simultaneous i_valid and i_clear:** clear wins and i_k_address is ignored.
- **Sweep:** covers rows 0..ROWS-1 in ascending order, each with the full PRE+ACT sequence. Exactly one o_done pulse is produced, at the end of the sweep.
- **Out-of-range address (address ≥ ROWS):** accepted, goes IDLE → DONE directly, with o_err=1 and o_done=1. No precharge and no select are issued.
- **Select integrity:** o_select is never multi-hot and is never nonzero while o_precharge=1. This holds in every cycle.
- **Registered outputs:** all outputs come from registers; there is no combinational path from input to output.

## Timing
- **Reset:** while i_rst_n=0, all outputs are 0, including o_ready. State is IDLE and the row register is 0. Assertion mid-access clears o_select immediately, without waiting for a clock.
- **After reset release:** o_ready rises on the first rising edge after i_rst_n goes high.
- **Single access accepted at edge k:**
  - o_precharge is high for cycles k+1 .. k+P.
  - o_select is active for cycles k+P+1 .. k+P+A.
  - o_done is high in cycle k+P+A+1.
  - o_ready returns in cycle k+P+A+2.
  - Here P = PRECHARGE_CYC and A = ACTIVE_CYC.
- **Throughput:** one access per P+A+2 cycles.
- **Sweep duration:** ROWS·(P+A) + 1 cycles from the first PRE cycle to the end of DONE.
- **Phase counter:** width is $clog2(max(P,A)+1). It reloads on every state entry and never wraps.
- **Row counter:** ADDR_W bits. It stops at ROWS-1 and does not wrap during a sweep.

## Structure
- **Package row_select_pkg:**
  - state enum type (IDLE, PRE, ACT, DONE).
  - shared counter-width helper function.
- **Sub-module row_decoder:** parametrised by ADDR_W and ROWS.
  - Purely combinational: address and enable in, one-hot out.
  - Drives zero when the enable is low or the address is ≥ ROWS.
  - Its output is registered by the sequencer, which then drives o_select.
- **Rest of the sequencer:** FSM, phase counter, row counter and output registers, all in row_select_sequencer.

## Test plan
All scenarios use ADDR_W=3, ROWS=8, P=1, A=2 unless stated.

1. **Reset with request pending:** hold i_rst_n=0 with i_valid=1 → all outputs stay 0. Release reset → o_ready=1 one edge later.
2. **Single access:** address 5 accepted at edge k → o_precharge=1 at k+1, o_select=8'b0010_0000 at k+2..k+3, o_done=1 at k+4, o_err=0.
3. **Sweep:** i_clear=1 together with i_valid=1 and address 3 → select walks 0x01, 0x02, ..., 0x80, each row preceded by one precharge cycle. A single o_done pulse follows 25 cycles after the first PRE.
4. **Out-of-range address:** with ROWS=6, address 7 → o_done=1 and o_err=1 one cycle after accept, o_select remains 0 throughout.
5. **Reset mid-access:** pull i_rst_n low during ACT on row 2 → o_select=0 asynchronously. After release, a new access to row 4 completes normally.
6. **Back-to-back requests:** hold i_valid=1 continuously → accepts occur exactly 5 cycles apart. The checker confirms o_select is never multi-hot and never overlaps o_precharge.

Source files
------------

// File: rtl/row_select_pkg.sv
// Shared types and helpers for the row-select sequencer and its decoder.
package row_select_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    ACT  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Width of a phase counter able to hold the longer of the two phase lengths.
  function automatic int unsigned cnt_width(input int unsigned p, input int unsigned a);
    int unsigned m;
    m = (p > a) ? p : a;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/row_decoder.sv
// Combinational address-to-one-hot row decoder; zero when disabled or out of range.
module row_decoder #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned ROWS   = 8
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              en,
  output logic [ROWS-1:0]   onehot
);

  // One bit per physical row; addresses at or beyond ROWS match nothing.
  always_comb begin
    onehot = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (en && (addr == ADDR_W'(r))) onehot[r] = 1'b1;
    end
  end

endmodule

// File: rtl/row_select_sequencer.sv
// Row-select sequencer: accepts one access per handshake and drives a
// precharge / active / done sequence, or sweeps every row on a clear request.
module row_select_sequencer
  import row_select_pkg::*;
#(
  parameter int unsigned ADDR_W        = 3,
  parameter int unsigned ROWS          = 8,
  parameter int unsigned PRECHARGE_CYC = 1,
  parameter int unsigned ACTIVE_CYC    = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [ADDR_W-1:0] i_k_address,
  input  logic              i_clear,
  output logic [ROWS-1:0]   o_select,
  output logic              o_precharge,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int unsigned       CNT_W    = cnt_width(PRECHARGE_CYC, ACTIVE_CYC);
  localparam logic [CNT_W-1:0]  PRE_LOAD = CNT_W'(PRECHARGE_CYC - 1);
  localparam logic [CNT_W-1:0]  ACT_LOAD = CNT_W'(ACTIVE_CYC - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
  localparam logic [ADDR_W:0]   ROWS_EXT = (ADDR_W + 1)'(ROWS);

  if ((ROWS < 2) || (ROWS > (1 << ADDR_W))) begin : g_bad_rows
    $error("row_select_sequencer: ROWS must satisfy 2 <= ROWS <= 2**ADDR_W");
  end
  if ((PRECHARGE_CYC < 1) || (ACTIVE_CYC < 1)) begin : g_bad_phase
    $error("row_select_sequencer: PRECHARGE_CYC and ACTIVE_CYC must be >= 1");
  end

  state_t            state, state_n;
  logic [ADDR_W-1:0] row, row_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              sweep, sweep_n;
  logic              err_n;
  logic              accept;
  logic [ROWS-1:0]   dec;

  assign accept = (i_valid | i_clear) & o_ready;

  // Decode the row that will be active next cycle so o_select can be registered.
  row_decoder #(
    .ADDR_W(ADDR_W),
    .ROWS  (ROWS)
  ) u_dec (
    .addr  (row_n),
    .en    (state_n == ACT),
    .onehot(dec)
  );

  // Next-state, phase counter reload/decrement and row advance.
  always_comb begin
    state_n = state;
    row_n   = row;
    cnt_n   = cnt;
    sweep_n = sweep;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (i_clear) begin
            state_n = PRE;
            row_n   = '0;
            sweep_n = 1'b1;
            cnt_n   = PRE_LOAD;
          end else if ({1'b0, i_k_address} >= ROWS_EXT) begin
            state_n = DONE;
            sweep_n = 1'b0;
            err_n   = 1'b1;
            cnt_n   = '0;
          end else begin
            state_n = PRE;
            row_n   = i_k_address;
            sweep_n = 1'b0;
            cnt_n   = PRE_LOAD;
          end
        end
      end
      PRE: begin
        if (cnt == '0) begin
          state_n = ACT;
          cnt_n   = ACT_LOAD;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      ACT: begin
        if (cnt == '0) begin
          if (sweep && (row != LAST_ROW)) begin
            state_n = PRE;
            row_n   = row + ADDR_W'(1);
            cnt_n   = PRE_LOAD;
          end else begin
            state_n = DONE;
            cnt_n   = '0;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
        sweep_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counters and row register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      row   <= '0;
      cnt   <= '0;
      sweep <= 1'b0;
    end else begin
      state <= state_n;
      row   <= row_n;
      cnt   <= cnt_n;
      sweep <= sweep_n;
    end
  end

  // Outputs are registered from the next-state view so they line up with the state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ready     <= 1'b0;
      o_precharge <= 1'b0;
      o_select    <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_ready     <= (state_n == IDLE);
      o_precharge <= (state_n == PRE);
      o_select    <= dec;
      o_busy      <= (state_n != IDLE);
      o_done      <= (state_n == DONE);
      o_err       <= err_n;
    end
  end

endmodule

// File: tb/tb_row_select_sequencer.sv
// Scoreboard bench for row_select_sequencer: an 8-row and a 6-row instance.
module tb_row_select_sequencer;

  localparam int unsigned P = 1;
  localparam int unsigned A = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       v8 = 1'b0, c8 = 1'b0;
  logic [2:0] a8 = '0;
  logic       rdy8, pre8, busy8, done8, err8;
  logic [7:0] sel8;

  logic       v6 = 1'b0, c6 = 1'b0;
  logic [2:0] a6 = '0;
  logic       rdy6, pre6, busy6, done6, err6;
  logic [5:0] sel6;

  int          checks = 0;
  int          fails  = 0;
  int unsigned cyc    = 0;

  // expected vector: [10]=done [9]=err [8]=precharge [7:0]=select
  logic [10:0] exp8[$];
  logic [10:0] exp6[$];
  logic [10:0] e8, e6;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  row_select_sequencer #(
    .ADDR_W(3), .ROWS(8), .PRECHARGE_CYC(P), .ACTIVE_CYC(A)
  ) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v8), .o_ready(rdy8),
    .i_k_address(a8), .i_clear(c8), .o_select(sel8), .o_precharge(pre8),
    .o_busy(busy8), .o_done(done8), .o_err(err8)
  );

  row_select_sequencer #(
    .ADDR_W(3), .ROWS(6), .PRECHARGE_CYC(P), .ACTIVE_CYC(A)
  ) dut6 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v6), .o_ready(rdy6),
    .i_k_address(a6), .i_clear(c6), .o_select(sel6), .o_precharge(pre6),
    .o_busy(busy6), .o_done(done6), .o_err(err6)
  );

  function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push_exp(input int d, input logic [10:0] v);
    if (d == 8) exp8.push_back(v);
    else exp6.push_back(v);
  endfunction

  // Expected per-busy-cycle outputs for one accepted request.
  function automatic void model(input int d, input bit clr, input int unsigned addr);
    int unsigned rows;
    rows = (d == 8) ? 8 : 6;
    if (clr) begin
      for (int unsigned r = 0; r < rows; r++) begin
        for (int unsigned i = 0; i < P; i++) push_exp(d, 11'h100);
        for (int unsigned i = 0; i < A; i++) push_exp(d, 11'(1) << r);
      end
      push_exp(d, 11'h400);
    end else if (addr >= rows) begin
      push_exp(d, 11'h600);
    end else begin
      for (int unsigned i = 0; i < P; i++) push_exp(d, 11'h100);
      for (int unsigned i = 0; i < A; i++) push_exp(d, 11'(1) << addr);
      push_exp(d, 11'h400);
    end
  endfunction

  // Wait for o_ready, present a request, record the accepting edge and push expectations.
  task automatic access(input int d, input bit clr, input bit vld, input logic [2:0] addr,
                        input bit hold, output int unsigned acc_cyc);
    int unsigned n;
    n = 0;
    acc_cyc = 0;
    @(negedge clk);
    while ((((d == 8) ? rdy8 : rdy6) !== 1'b1) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    if (((d == 8) ? rdy8 : rdy6) !== 1'b1) begin
      checks++;
      fails++;
      $display("FAIL ready_timeout%0d: o_ready 0 after %0d cycles, expected 1", d, n);
      return;
    end
    if (d == 8) begin v8 = vld; c8 = clr; a8 = addr; end
    else        begin v6 = vld; c6 = clr; a6 = addr; end
    @(posedge clk);
    acc_cyc = cyc;
    model(d, clr, int'(addr));
    #1;
    if (!hold) begin
      if (d == 8) begin v8 = 1'b0; c8 = 1'b0; end
      else        begin v6 = 1'b0; c6 = 1'b0; end
    end
  endtask

  // Monitor for the 8-row instance.
  always @(negedge clk) begin
    if (rst_n) begin
      cmp("sel_onehot8", 32'($countones(sel8) <= 1), 32'd1);
      cmp("sel_pre_excl8", 32'(pre8 && (sel8 != '0)), 32'd0);
      if (busy8) begin
        if (exp8.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL out8: busy output %0h with nothing expected", {done8, err8, pre8, sel8});
        end else begin
          e8 = exp8.pop_front();
          cmp("out8", {done8, err8, pre8, sel8}, e8);
        end
      end else begin
        cmp("idle8", {done8, pre8, sel8}, 0);
        cmp("pending8", exp8.size(), 0);
      end
    end
  end

  // Monitor for the 6-row instance.
  always @(negedge clk) begin
    if (rst_n) begin
      cmp("sel_onehot6", 32'($countones(sel6) <= 1), 32'd1);
      cmp("sel_pre_excl6", 32'(pre6 && (sel6 != '0)), 32'd0);
      if (busy6) begin
        if (exp6.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL out6: busy output %0h with nothing expected", {done6, err6, pre6, sel6});
        end else begin
          e6 = exp6.pop_front();
          cmp("out6", {done6, err6, pre6, 2'b00, sel6}, e6);
        end
      end else begin
        cmp("idle6", {done6, pre6, sel6}, 0);
        cmp("pending6", exp6.size(), 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t0, t1, tk;
    int unsigned n;

    // Reset held with a request pending.
    v8 = 1'b1; a8 = 3'd5; v6 = 1'b1; a6 = 3'd1;
    repeat (3) @(negedge clk);
    cmp("rst_ready8", rdy8, 0);
    cmp("rst_outs8", {pre8, busy8, done8, err8, sel8}, 0);
    cmp("rst_outs6", {rdy6, pre6, busy6, done6, err6, sel6}, 0);
    rst_n = 1'b1;
    #1;
    cmp("ready_before_edge", rdy8, 0);
    @(negedge clk);
    cmp("ready_after_release8", rdy8, 1);
    cmp("ready_after_release6", rdy6, 1);
    v8 = 1'b0; v6 = 1'b0;

    // Single access to row 5.
    access(8, 1'b0, 1'b1, 3'd5, 1'b0, t0);

    // Clear together with valid: sweep all rows, address ignored.
    access(8, 1'b1, 1'b1, 3'd3, 1'b0, t0);

    // Out-of-range and edge addresses on the 6-row instance, then a clear-only sweep.
    access(6, 1'b0, 1'b1, 3'd7, 1'b0, t0);
    access(6, 1'b0, 1'b1, 3'd6, 1'b0, t0);
    access(6, 1'b0, 1'b1, 3'd5, 1'b0, t0);
    access(6, 1'b1, 1'b0, 3'd0, 1'b0, t0);

    // Reset asserted during the active phase of row 2.
    access(8, 1'b0, 1'b1, 3'd2, 1'b0, tk);
    @(posedge clk);
    #2;
    cmp("act_row2_sel", sel8, 8'h04);
    rst_n = 1'b0;
    #1;
    cmp("async_rst_sel", sel8, 8'h00);
    cmp("async_rst_busy", busy8, 0);
    exp8.delete();
    exp6.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    access(8, 1'b0, 1'b1, 3'd4, 1'b0, t0);

    // Back-to-back with valid held high.
    access(8, 1'b0, 1'b1, 3'd0, 1'b1, t0);
    access(8, 1'b0, 1'b1, 3'd7, 1'b1, t1);
    cmp("spacing_0_7", t1 - t0, P + A + 2);
    access(8, 1'b0, 1'b1, 3'd3, 1'b1, t0);
    cmp("spacing_7_3", t0 - t1, P + A + 2);
    access(8, 1'b0, 1'b1, 3'd1, 1'b0, t1);
    cmp("spacing_3_1", t1 - t0, P + A + 2);

    // Drain outstanding expectations.
    n = 0;
    while (((exp8.size() != 0) || (exp6.size() != 0) || busy8 || busy6) && (n < 100)) begin
      @(negedge clk);
      n++;
    end
    cmp("drain", exp8.size() + exp6.size(), 0);
    @(negedge clk);
    cmp("final_ready8", rdy8, 1);
    cmp("final_ready6", rdy6, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
